// File: rtl/i2s_audio_in.sv
// I2S receiver: oversamples bclk/lrclk/sdata in the clk domain and delivers
// left/right sample pairs through a valid/ready hold register.
module i2s_audio_in #(
  parameter int in_res              = 16,
  parameter int align_right         = 0,
  parameter int offset_by_one_cycle = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [in_res-1:0] left,
  output logic [in_res-1:0] right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int OFF     = (offset_by_one_cycle != 0) ? 1 : 0;
  localparam bit RALIGN  = (align_right != 0);
  localparam int MIN_LEN = RALIGN ? in_res : OFF + in_res;

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  logic bclk_s1_q, bclk_s1_d, bclk_s2_q, bclk_s2_d;
  logic bclk_prev_q, bclk_prev_d;
  logic lr_s1_q, lr_s1_d, lr_s2_q, lr_s2_d;
  logic sd_s1_q, sd_s1_d, sd_s2_q, sd_s2_d;
  logic rise_q, rise_d;
  logic lr_smp_q, lr_smp_d, sd_smp_q, sd_smp_d;
  logic lr_prev_q, lr_prev_d;
  logic [5:0] k_q, k_d;
  state_t state_q, state_d;
  logic [in_res-1:0] sr_q, sr_d, lbuf_q, lbuf_d;
  logic lbad_q, lbad_d;
  logic [in_res-1:0] left_q, left_d, right_q, right_d;
  logic valid_q, valid_d, overrun_q, overrun_d, ferr_q, ferr_d;

  logic [5:0] k_inc, cur_k;
  logic change, take, slot_ok, deliver;
  logic [in_res-1:0] sr_shift, slot_val;

  always_comb begin
    bclk_s1_d   = bclk;
    bclk_s2_d   = bclk_s1_q;
    bclk_prev_d = bclk_s2_q;
    lr_s1_d     = lrclk;
    lr_s2_d     = lr_s1_q;
    sd_s1_d     = sdata;
    sd_s2_d     = sd_s1_q;
    rise_d      = bclk_s2_q & ~bclk_prev_q;
    lr_smp_d    = rise_d ? lr_s2_q : lr_smp_q;
    sd_smp_d    = rise_d ? sd_s2_q : sd_smp_q;

    lr_prev_d = lr_prev_q;
    k_d       = k_q;
    state_d   = state_q;
    sr_d      = sr_q;
    lbuf_d    = lbuf_q;
    lbad_d    = lbad_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;
    deliver   = 1'b0;

    change   = lr_smp_q ^ lr_prev_q;
    k_inc    = (k_q == 6'd63) ? 6'd63 : k_q + 6'd1;
    cur_k    = change ? 6'd0 : k_inc;
    take     = RALIGN || ((int'(cur_k) >= OFF) &&
                          (int'(cur_k) < OFF + in_res));
    slot_ok  = (int'(k_q) + 1) >= MIN_LEN;
    sr_shift = {sr_q[in_res-2:0], sd_smp_q};
    // with the one-cycle offset the edge bit still belongs to the old slot
    slot_val = (RALIGN && OFF == 1) ? sr_shift : sr_q;

    if (rise_q) begin
      k_d       = cur_k;
      lr_prev_d = lr_smp_q;
      if (take) sr_d = sr_shift;
      if (change) begin
        unique case (state_q)
          SYNC: if (!lr_smp_q) state_d = LEFT;
          LEFT: begin
            state_d = RIGHT;
            lbuf_d  = slot_val;
            lbad_d  = !slot_ok;
            if (!slot_ok) ferr_d = 1'b1;
          end
          RIGHT: begin
            state_d = LEFT;
            if (!slot_ok) ferr_d = 1'b1;
            else if (!lbad_q) deliver = 1'b1;
          end
          default: state_d = SYNC;
        endcase
      end
    end

    if (deliver) begin
      if (valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        left_d  = lbuf_q;
        right_d = slot_val;
        valid_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      lr_s1_q     <= 1'b0;
      lr_s2_q     <= 1'b0;
      sd_s1_q     <= 1'b0;
      sd_s2_q     <= 1'b0;
      rise_q      <= 1'b0;
      lr_smp_q    <= 1'b0;
      sd_smp_q    <= 1'b0;
      lr_prev_q   <= 1'b0;
      k_q         <= '0;
      state_q     <= SYNC;
      sr_q        <= '0;
      lbuf_q      <= '0;
      lbad_q      <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      bclk_s1_q   <= bclk_s1_d;
      bclk_s2_q   <= bclk_s2_d;
      bclk_prev_q <= bclk_prev_d;
      lr_s1_q     <= lr_s1_d;
      lr_s2_q     <= lr_s2_d;
      sd_s1_q     <= sd_s1_d;
      sd_s2_q     <= sd_s2_d;
      rise_q      <= rise_d;
      lr_smp_q    <= lr_smp_d;
      sd_smp_q    <= sd_smp_d;
      lr_prev_q   <= lr_prev_d;
      k_q         <= k_d;
      state_q     <= state_d;
      sr_q        <= sr_d;
      lbuf_q      <= lbuf_d;
      lbad_q      <= lbad_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_i2s_audio_in.sv
// Bench for i2s_audio_in: a bit-level I2S source plus scoreboard queues
// feeding a default receiver and a right-justified, zero-offset receiver.
module tb_i2s_audio_in;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
  logic rdy0 = 1'b1, rdy1 = 1'b1;
  logic [15:0] l0, r0, l1, r1;
  logic v0, v1, ov0, ov1, fe0, fe1;

  i2s_audio_in dut0 (
    .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left(l0), .right(r0), .out_valid(v0), .out_ready(rdy0),
    .overrun(ov0), .frame_err(fe0)
  );

  i2s_audio_in #(
    .in_res(16), .align_right(1), .offset_by_one_cycle(0)
  ) dut1 (
    .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left(l1), .right(r1), .out_valid(v1), .out_ready(rdy1),
    .overrun(ov1), .frame_err(fe1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp0[$], exp1[$], got0[$], got1[$];
  int vcnt0 = 0, vrise0 = 0;
  logic vprev0 = 1'b0;

  always @(negedge clk) begin
    if (v0 && rdy0) got0.push_back({l0, r0});
    if (v1 && rdy1) got1.push_back({l1, r1});
    if (v0) vcnt0++;
    if (v0 && !vprev0) vrise0 = cyc;
    vprev0 = v0;
  end

  int nvec = 0, nerr = 0;
  logic [127:0] strm;
  int cur_slot = 32;
  logic carry = 1'b0;
  int rise_cyc = 0;

  task automatic send_bit(input logic lr, input logic sd);
    bclk = 1'b0; lrclk = lr; sdata = sd;
    repeat (4) @(negedge clk);
    bclk = 1'b1; rise_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  task automatic build(input logic [31:0] l, input logic [31:0] r,
                       input int slot, input int width,
                       input int offb, input int ralign);
    logic [31:0] w;
    int p;
    strm = '0; strm[0] = carry; carry = 1'b0; cur_slot = slot;
    for (int c = 0; c < 2; c++) begin
      w = (c == 0) ? l : r;
      for (int j = 0; j < width; j++) begin
        p = c * slot + ((ralign != 0) ? slot - width + offb : offb) + j;
        if (p == 2 * slot) carry = w[width-1-j];
        else strm[p] = w[width-1-j];
      end
    end
  endtask

  task automatic play(input int from, input int to);
    for (int p = from; p < to; p++) send_bit(p >= cur_slot, strm[p]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int slot, input int width, input int offb,
                            input int ralign, input int which);
    build(l, r, slot, width, offb, ralign);
    if (which == 0) exp0.push_back({l[15:0], r[15:0]});
    else if (which == 1) exp1.push_back({l[15:0], r[15:0]});
    play(0, 2 * slot);
  endtask

  task automatic preamble();
    repeat (2) send_bit(1'b1, 1'b0);
  endtask

  task automatic tail();
    send_bit(1'b0, carry);
    carry = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; carry = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nvec++;
    if ({l0, r0, v0, ov0, fe0} !== 35'd0) begin
      nerr++;
      $display("FAIL reset_dut0 got %h required 0", {l0, r0, v0, ov0, fe0});
    end
    nvec++;
    if ({l1, r1, v1, ov1, fe1} !== 35'd0) begin
      nerr++;
      $display("FAIL reset_dut1 got %h required 0", {l1, r1, v1, ov1, fe1});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int start;
    logic [31:0] e, g;
    do_reset();
    rdy0 = 1'b1;
    start = vcnt0;
    preamble();
    send_frame(32'h1234, 32'hABCD, 32, 16, 1, 0, 0);
    send_frame(32'h5A5A, 32'h0F0F, 32, 16, 1, 0, 0);
    tail();
    nvec++;
    if (vrise0 - rise_cyc != 4) begin
      nerr++;
      $display("FAIL latency got %0d required 4", vrise0 - rise_cyc);
    end
    while (exp0.size() > 0) begin
      e = exp0.pop_front();
      nvec++;
      if (got0.size() == 0) begin
        nerr++;
        $display("FAIL basic_frame got none required %h", e);
      end else begin
        g = got0.pop_front();
        if (g !== e) begin
          nerr++;
          $display("FAIL basic_frame got %h required %h", g, e);
        end
      end
    end
    nvec++;
    if (vcnt0 - start != 2) begin
      nerr++;
      $display("FAIL valid_pulses got %0d required 2", vcnt0 - start);
    end
    nvec++;
    if ({ov0, fe0} !== 2'b00) begin
      nerr++;
      $display("FAIL basic_flags got %b required 00", {ov0, fe0});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] g;
    do_reset();
    rdy0 = 1'b0;
    preamble();
    send_frame(32'h1111, 32'h2222, 32, 16, 1, 0, 0);
    send_frame(32'h3333, 32'h4444, 32, 16, 1, 0, -1);
    tail();
    nvec++;
    if ({v0, l0, r0, ov0} !== {1'b1, 32'h1111_2222, 1'b1}) begin
      nerr++;
      $display("FAIL hold got v=%b %h/%h ov=%b required v=1 1111/2222 ov=1",
               v0, l0, r0, ov0);
    end
    @(posedge clk);
    #1 rdy0 = 1'b1;
    repeat (2) @(negedge clk);
    nvec++;
    if (v0 !== 1'b0) begin
      nerr++;
      $display("FAIL accept_clear got %b required 0", v0);
    end
    nvec++;
    if (ov0 !== 1'b1) begin
      nerr++;
      $display("FAIL overrun_sticky got %b required 1", ov0);
    end
    nvec++;
    if (got0.size() != 1) begin
      nerr++;
      $display("FAIL accept_count got %0d required 1", got0.size());
    end else begin
      g = got0.pop_front();
      if (g !== exp0.pop_front()) begin
        nerr++;
        $display("FAIL accept_frame got %h required 11112222", g);
      end
    end
  endtask

  task automatic test_short_slot();
    int start;
    do_reset();
    rdy0 = 1'b1;
    start = vcnt0;
    preamble();
    send_frame(32'hAA, 32'h55, 8, 8, 1, 0, -1);
    send_frame(32'hC3, 32'h3C, 8, 8, 1, 0, -1);
    tail();
    nvec++;
    if (fe0 !== 1'b1) begin
      nerr++;
      $display("FAIL short_err got %b required 1", fe0);
    end
    nvec++;
    if (vcnt0 != start || got0.size() != 0) begin
      nerr++;
      $display("FAIL short_valid got %0d required 0", vcnt0 - start);
    end
  endtask

  task automatic test_right_aligned();
    logic [31:0] e, g;
    do_reset();
    rdy1 = 1'b1;
    preamble();
    send_frame(32'h008001, 32'h00FFFE, 24, 24, 0, 1, 1);
    tail();
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      nvec++;
      if (got1.size() == 0) begin
        nerr++;
        $display("FAIL ralign_frame got none required %h", e);
      end else begin
        g = got1.pop_front();
        if (g !== e) begin
          nerr++;
          $display("FAIL ralign_frame got %h required %h", g, e);
        end
      end
    end
    nvec++;
    if (fe1 !== 1'b0) begin
      nerr++;
      $display("FAIL ralign_err got %b required 0", fe1);
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [31:0] e, g;
    do_reset();
    rdy0 = 1'b1;
    preamble();
    send_frame(32'hC0DE, 32'hBEEF, 32, 16, 1, 0, 0);
    build(32'hDEAD, 32'hFACE, 32, 16, 1, 0);
    play(0, 40);
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({l0, r0, v0, ov0, fe0} !== 35'd0) begin
      nerr++;
      $display("FAIL midreset got %h required 0", {l0, r0, v0, ov0, fe0});
    end
    rst = 1'b0;
    play(40, 64);
    send_frame(32'h1357, 32'h2468, 32, 16, 1, 0, 0);
    tail();
    while (exp0.size() > 0) begin
      e = exp0.pop_front();
      nvec++;
      if (got0.size() == 0) begin
        nerr++;
        $display("FAIL midreset_frame got none required %h", e);
      end else begin
        g = got0.pop_front();
        if (g !== e) begin
          nerr++;
          $display("FAIL midreset_frame got %h required %h", g, e);
        end
      end
    end
    nvec++;
    if (got0.size() != 0) begin
      nerr++;
      $display("FAIL midreset_extra got %0d required 0", got0.size());
    end
  endtask

  task automatic test_loopback();
    logic [31:0] e, g;
    logic [15:0] s;
    do_reset();
    rdy0 = 1'b1;
    preamble();
    for (int i = 0; i < 6; i++) begin
      s = 16'h0123 + 16'(i) * 16'h1111;
      send_frame({16'h0, s}, {16'h0, ~s}, 32, 16, 1, 0, 0);
    end
    tail();
    while (exp0.size() > 0) begin
      e = exp0.pop_front();
      nvec++;
      if (got0.size() == 0) begin
        nerr++;
        $display("FAIL ramp_frame got none required %h", e);
      end else begin
        g = got0.pop_front();
        if (g !== e) begin
          nerr++;
          $display("FAIL ramp_frame got %h required %h", g, e);
        end
      end
    end
    nvec++;
    if ({ov0, fe0} !== 2'b00) begin
      nerr++;
      $display("FAIL ramp_flags got %b required 00", {ov0, fe0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_slot();
    test_right_aligned();
    test_reset_mid_slot();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
